// File: rtl/uncache_unit.sv
// uncache_unit: single-outstanding uncached load/store engine for the MEM stage.
// It latches one request and issues a single-beat read or write. Load data is
// held in uncache_Out until the next captured read beat.
module uncache_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        op,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data,
    input  logic        wr_rdy,
    output logic        MEM_unCache_data_ok,
    output logic [31:0] uncache_Out,
    output logic        uncache_last_stall,
    output logic        MEM_uncache_rd_req,
    output logic [2:0]  MEM_uncache_rd_type,
    output logic [31:0] MEM_uncache_rd_addr,
    output logic        MEM_uncache_wr_req,
    output logic [2:0]  MEM_uncache_wr_type,
    output logic [31:0] MEM_uncache_wr_addr,
    output logic [3:0]  MEM_uncache_wr_wstrb,
    output logic [31:0] MEM_uncache_wr_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_q;
    logic        op_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic        req_q;      // memory-side request pending (read or write per op_q)
    logic [31:0] out_q;

    // FSM, request registers and load-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
            req_q   <= 1'b0;
            out_q   <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        op_q    <= op;
                        addr_q  <= addr;
                        size_q  <= size;
                        wstrb_q <= wstrb;
                        wdata_q <= wdata;
                        req_q   <= 1'b1;
                        state_q <= op ? WR_REQ : RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (rd_rdy) begin
                        req_q   <= 1'b0;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // every beat is captured so the last one wins
                    if (ret_valid) begin
                        out_q <= ret_data;
                        if (ret_last) state_q <= DONE;
                    end
                end
                WR_REQ: begin
                    if (wr_rdy) begin
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // a valid seen here belongs to the next instruction; take it next cycle
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MEM_unCache_data_ok  = ((state_q == IDLE) && !valid) || (state_q == DONE);
    assign uncache_last_stall   = (state_q == DONE);
    assign uncache_Out          = out_q;

    assign MEM_uncache_rd_req   = req_q && !op_q;
    assign MEM_uncache_rd_type  = {1'b0, size_q};
    assign MEM_uncache_rd_addr  = addr_q;
    assign MEM_uncache_wr_req   = req_q && op_q;
    assign MEM_uncache_wr_type  = {1'b0, size_q};
    assign MEM_uncache_wr_addr  = addr_q;
    assign MEM_uncache_wr_wstrb = wstrb_q;
    assign MEM_uncache_wr_data  = wdata_q;

endmodule

// File: doc/uncache_unit.md
# uncache_unit

Single-outstanding uncached load/store engine for the MEM stage. Accepts a request when the MEM1 uncached path asserts `MEM1_uncache_valid` (address segment 0xA000_0000–0xBFFF_FFFF). Issues one single-beat read or write on the memory-side request interface and returns load data. Produces `MEM_unCache_data_ok`, `uncache_Out` and the `uncache_last_stall` pulse consumed by the MEM-stage cache/uncache select and the dcache gating logic.

## Interface
Parameters: none.

Clock and reset: one clock; reset is asynchronous and active-high.

- `clk` in 1 — core clock.
- `rst` in 1 — asynchronous reset, active-high.
- `valid` in 1 — uncached request; driven from `MEM1_uncache_valid`.
- `op` in 1 — 1 = store, 0 = load; driven from the gated MEM1 write enable.
- `addr` in 32 — physical address `{3'b000, vaddr[28:0]}`.
- `size` in 2 — 00 byte, 01 half, 10 word.
- `wstrb` in 4 — byte strobes from MEM1.
- `wdata` in 32 — store data, already lane-aligned.
- `rd_rdy` in 1 — read request accepted by the memory side.
- `ret_valid` in 1 — read return beat valid.
- `ret_last` in 1 — last return beat.
- `ret_data` in 32 — return data.
- `wr_rdy` in 1 — write request accepted by the memory side.
- `MEM_unCache_data_ok` out 1 — unit not holding the pipeline.
- `uncache_Out` out 32 — last completed load data.
- `uncache_last_stall` out 1 — one-cycle pulse on the final stall cycle.
- `MEM_uncache_rd_req` out 1 — read request.
- `MEM_uncache_rd_type` out 3 — read size: 000 byte, 001 half, 010 word.
- `MEM_uncache_rd_addr` out 32 — read address.
- `MEM_uncache_wr_req` out 1 — write request.
- `MEM_uncache_wr_type` out 3 — write size: 000 byte, 001 half, 010 word.
- `MEM_uncache_wr_addr` out 32 — write address.
- `MEM_uncache_wr_wstrb` out 4 — write strobes.
- `MEM_uncache_wr_data` out 32 — write data.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- **IDLE**
  - On `valid`, latch `op`, `addr`, `size`, `wstrb` and `wdata` into request registers.
  - Next state is RD_REQ (`op`=0) or WR_REQ (`op`=1).
  - Without `valid`, stay in IDLE.
- **RD_REQ**
  - `MEM_uncache_rd_req`=1; rd_addr and rd_type come from the latched request, with `rd_type={1'b0,size}`.
  - On `rd_rdy`, go to RD_WAIT.
  - The request stays asserted and stable until `rd_rdy`.
- **RD_WAIT**
  - On `ret_valid`, register `ret_data` into `uncache_Out`.
  - If `ret_last` is also set, go to DONE.
  - Beats with `ret_last`=0 are captured, but the state does not advance. The last beat's data wins.
- **WR_REQ**
  - `MEM_uncache_wr_req`=1; wr_addr, wr_type, wstrb and wr_data come from the latched request.
  - On `wr_rdy`, go to DONE.
- **DONE** — unconditionally returns to IDLE. `valid` seen in DONE is ignored; the pipeline advances in this cycle and presents any new request in the following cycle.
- Output equations:
  - `MEM_unCache_data_ok` = (IDLE & !valid) | DONE.
  - `uncache_last_stall` = DONE.
- `uncache_Out` changes only on a captured read beat. It holds across stores and idle time.
- Outputs are bit-exact pass-through of the latched fields; no address alignment is done here.
- Address errors are excluded upstream and never reach this unit.
- **Reset** (async, any state): state=IDLE, `uncache_Out`=0, request registers=0, all req outputs=0. `MEM_unCache_data_ok` follows its equation and reads 1 once `valid` is low.
- A transfer in flight when `rst` asserts is abandoned; the memory side is reset by the same `rst`.

## Timing
- Accept in cycle T (IDLE & `valid`): `MEM_unCache_data_ok`=0 in T. The request is visible from T+1.
- Fastest load:
  - `rd_rdy` at T+1.
  - `ret_valid`&`ret_last` at T+2.
  - DONE at T+3: `uncache_Out` valid, `MEM_unCache_data_ok`=1, `uncache_last_stall`=1.
  - IDLE at T+4.
- Fastest store: `wr_rdy` at T+1, DONE at T+2, IDLE at T+3.
- `rd_req` and `wr_req` are never asserted in the same cycle. Each request deasserts in the cycle after its handshake.
- `MEM_unCache_data_ok` is 0 on every cycle from accept through the cycle before DONE.
- A new request can be accepted no earlier than one cycle after DONE.
- `ret_valid` is ignored outside RD_WAIT. `rd_rdy` and `wr_rdy` are ignored outside their REQ states.

## Test plan
- **Word load, zero wait.**
  - Stimulus: `valid`=1, `op`=0, `addr`=0x1FAF_F010, `size`=10; `rd_rdy` in T+1; `ret_valid`=`ret_last`=1 with `ret_data`=0xDEAD_BEEF in T+2.
  - Required: `rd_type`=010 and `rd_addr`=0x1FAF_F010 in T+1; `uncache_Out`=0xDEAD_BEEF and `uncache_last_stall`=1 in T+3; `data_ok` low in T..T+2.
- **Byte store with backpressure.**
  - Stimulus: `op`=1, `addr`=0x1FAF_F003, `size`=00, `wstrb`=1000, `wdata`=0xAB00_0000; `wr_rdy` held low for 3 cycles.
  - Required: `wr_req`, address, strobe and data stable for 4 cycles; DONE the cycle after `wr_rdy`; `uncache_Out` unchanged.
- **Multi-beat return.**
  - Stimulus: beats 0x1111_1111 with `ret_last`=0, then 0x2222_2222 with `ret_last`=1.
  - Required: final `uncache_Out`=0x2222_2222; DONE only after the last beat.
- **Back-to-back requests.**
  - Stimulus: `valid` held high through DONE; new request fields presented the cycle after DONE.
  - Required: the second request is accepted the cycle after DONE, not in DONE, and the second latched address appears on the bus.
- **Async reset mid-read.**
  - Stimulus: `rst` pulsed while in RD_WAIT.
  - Required: immediately `rd_req`=0, `uncache_Out`=0, state IDLE; `data_ok`=1 once `valid` is low.
- **Spurious handshakes in IDLE.**
  - Stimulus: `ret_valid`, `rd_rdy` and `wr_rdy` pulsed while idle.
  - Required: no state change and no change to `uncache_Out`.
